// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared types and constants for the MIPS instruction fetch stage: address and
// instruction word types, reset PC, sequential step, chip-enable encodings,
// the fetch FSM state encoding and word-alignment helpers.
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    localparam inst_addr_t IF_RESET_PC  = 32'h0000_0000;
    localparam inst_addr_t IF_PC_STEP   = 32'd4;
    localparam inst_t      ZERO_WORD    = 32'h0000_0000;
    localparam logic       CHIP_ENABLE  = 1'b1;
    localparam logic       CHIP_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2
    } if_state_e;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic inst_addr_t align_word(input inst_addr_t addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input inst_addr_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundle of the fetch stage's control inputs, ROM port and IF/ID outputs.
//   master : the fetch unit (drives ce/pc, IF/ID outputs, misalign, count)
//   slave  : the surrounding pipeline and ROM (drives stall, branch, flush,
//            new_pc and the ROM instruction word)
// -----------------------------------------------------------------------------
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic       stall;
    logic       branch_flag;
    inst_addr_t branch_target;
    logic       flush;
    inst_addr_t new_pc;
    inst_t      inst;
    logic       ce;
    inst_addr_t pc;
    inst_addr_t id_pc;
    inst_t      id_inst;
    logic       id_valid;
    logic       misalign;
    logic [31:0] fetch_count;

    modport master (
        input  stall, branch_flag, branch_target, flush, new_pc, inst,
        output ce, pc, id_pc, id_inst, id_valid, misalign, fetch_count
    );

    modport slave (
        output stall, branch_flag, branch_target, flush, new_pc, inst,
        input  ce, pc, id_pc, id_inst, id_valid, misalign, fetch_count
    );

endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Holds when neither load nor flush is asserted;
// flush turns the slot into a bubble (zero instruction, valid low).
//   clk, rst  : clock, synchronous active-low reset
//   load      : capture pc/inst as a valid instruction
//   flush     : insert a bubble (wins over load)
//   pc, inst  : fetch address and ROM word being captured
//   id_pc, id_inst, id_valid : register outputs toward ID
// -----------------------------------------------------------------------------
module if_id_reg
    import if_fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       flush,
    input  inst_addr_t pc,
    input  inst_t      inst,
    output inst_addr_t id_pc,
    output inst_t      id_inst,
    output logic       id_valid
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_pc    <= '0;
            id_inst  <= ZERO_WORD;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_inst  <= ZERO_WORD;
            id_valid <= 1'b0;
        end else if (load) begin
            id_pc    <= pc;
            id_inst  <= inst;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: registered PC and ROM chip enable, IF/ID capture,
// stall hold, branch redirect with delay slot, pending branch across a stall,
// exception flush, misaligned-target pulse and delivered-instruction count.
//   clk, rst : clock, synchronous active-low reset
//   bus      : if_fetch_unit_if.master (control in, ROM port, IF/ID out)
// Parameters: RESET_PC fetch address after reset; COUNT_INIT reset value of
// the delivered-instruction counter.
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter inst_addr_t  RESET_PC   = IF_RESET_PC,
    parameter logic [31:0] COUNT_INIT = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    if_fetch_unit_if.master bus
);

    if_state_e   state_q, state_d;
    inst_addr_t  pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        pend_valid_q, pend_valid_d;
    inst_addr_t  pend_target_q, pend_target_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;
    logic        id_load, id_flush;
    logic        redirect_en;
    inst_addr_t  redirect_pc;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        ce_d          = ce_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        misalign_d    = 1'b0;
        count_d       = count_q;
        id_load       = 1'b0;
        id_flush      = 1'b0;
        redirect_en   = 1'b0;
        redirect_pc   = pc_q;

        case (state_q)
            S_RESET: begin
                // One settling cycle with the ROM disabled, PC already at RESET_PC.
                state_d = S_FETCH;
                ce_d    = CHIP_ENABLE;
            end
            S_FETCH, S_STALL: begin
                if (bus.flush) begin
                    // Flush beats stall and branch; the IF/ID slot becomes a bubble.
                    id_flush     = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = S_FETCH;
                    redirect_en  = 1'b1;
                    redirect_pc  = bus.new_pc;
                end else if (bus.stall) begin
                    state_d = S_STALL;
                    if (bus.branch_flag) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = bus.branch_target;
                    end
                end else begin
                    // The word in IF now is the delay slot of any branch seen this
                    // cycle, so it is always delivered before the redirect.
                    id_load      = 1'b1;
                    count_d      = count_q + 32'd1;
                    state_d      = S_FETCH;
                    pend_valid_d = 1'b0;
                    if (bus.branch_flag) begin
                        redirect_en = 1'b1;
                        redirect_pc = bus.branch_target;
                    end else if (pend_valid_q) begin
                        redirect_en = 1'b1;
                        redirect_pc = pend_target_q;
                    end else begin
                        pc_d = pc_q + IF_PC_STEP;
                    end
                end
            end
            default: begin
                state_d = S_RESET;
                ce_d    = CHIP_DISABLE;
            end
        endcase

        if (redirect_en) begin
            pc_d       = align_word(redirect_pc);
            misalign_d = is_misaligned(redirect_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_RESET;
            pc_q          <= RESET_PC;
            ce_q          <= CHIP_DISABLE;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            misalign_q    <= 1'b0;
            count_q       <= COUNT_INIT;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ce_q          <= ce_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            misalign_q    <= misalign_d;
            count_q       <= count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (id_load),
        .flush    (id_flush),
        .pc       (pc_q),
        .inst     (bus.inst),
        .id_pc    (bus.id_pc),
        .id_inst  (bus.id_inst),
        .id_valid (bus.id_valid)
    );

    assign bus.ce          = ce_q;
    assign bus.pc          = pc_q;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit. A combinational ROM model returns a word
// derived from the address. A second instance whose counter resets to
// 32'hFFFF_FFFF runs unstalled to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    if_fetch_unit_if bus ();
    if_fetch_unit_if bus_w ();

    function automatic inst_t rom_word(input inst_addr_t a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    assign bus.inst   = rom_word(bus.pc);
    assign bus_w.inst = rom_word(bus_w.pc);

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    if_fetch_unit #(.COUNT_INIT(32'hFFFF_FFFF)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled and inputs driven
    // away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic br, input inst_addr_t tgt,
                         input logic fl, input inst_addr_t npc);
        bus.stall         = stall;
        bus.branch_flag   = br;
        bus.branch_target = tgt;
        bus.flush         = fl;
        bus.new_pc        = npc;
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        bus_w.stall = 1'b0; bus_w.branch_flag = 1'b0; bus_w.branch_target = '0;
        bus_w.flush = 1'b0; bus_w.new_pc = '0;

        // Reset held for three cycles.
        rst = 1'b0;
        repeat (3) tick();
        check("rst_ce", {31'd0, bus.ce}, 32'd0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rst_id_inst", bus.id_inst, 32'h0);
        check("rst_count", bus.fetch_count, 32'd0);
        check("rst_misalign", {31'd0, bus.misalign}, 32'd0);
        check("wrap_rst_count", bus_w.fetch_count, 32'hFFFF_FFFF);

        rst = 1'b1;
        check("rel_ce_low", {31'd0, bus.ce}, 32'd0);
        tick(); // E1
        check("e1_ce", {31'd0, bus.ce}, 32'd1);
        check("e1_pc", bus.pc, 32'h0);
        check("e1_id_valid", {31'd0, bus.id_valid}, 32'd0);
        check("wrap_e1_count", bus_w.fetch_count, 32'hFFFF_FFFF);
        tick(); // E2
        check("e2_pc", bus.pc, 32'h4);
        check("e2_id_valid", {31'd0, bus.id_valid}, 32'd1);
        check("e2_id_pc", bus.id_pc, 32'h0);
        check("e2_count", bus.fetch_count, 32'd1);
        check("wrap_e2_count", bus_w.fetch_count, 32'h0);
        tick(); // E3
        check("e3_pc", bus.pc, 32'h8);
        check("e3_id_inst", bus.id_inst, 32'hC0DE_0004);
        tick(); tick(); // E4, E5
        check("e5_pc", bus.pc, 32'h10);

        // Branch with delay slot.
        drive(1'b0, 1'b1, 32'h100, 1'b0, '0);
        tick(); // E6
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        check("br_pc", bus.pc, 32'h100);
        check("br_delay_id_pc", bus.id_pc, 32'h10);
        check("br_delay_id_inst", bus.id_inst, 32'hC0DE_0010);
        check("br_count", bus.fetch_count, 32'd5);
        tick(); // E7
        check("br_tgt_id_pc", bus.id_pc, 32'h100);
        check("br_next_pc", bus.pc, 32'h104);

        // Branch during a three-cycle stall.
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        tick(); // E8
        check("st1_pc", bus.pc, 32'h104);
        check("st1_id_pc", bus.id_pc, 32'h100);
        drive(1'b1, 1'b1, 32'h200, 1'b0, '0);
        tick(); // E9
        check("st2_pc", bus.pc, 32'h104);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        tick(); // E10
        check("st3_pc", bus.pc, 32'h104);
        check("st3_count", bus.fetch_count, 32'd6);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        tick(); // E11
        check("rel_pc", bus.pc, 32'h200);
        check("rel_id_pc", bus.id_pc, 32'h104);
        check("rel_count", bus.fetch_count, 32'd7);
        tick(); // E12
        check("rel2_id_pc", bus.id_pc, 32'h200);
        check("rel2_pc", bus.pc, 32'h204);

        // Flush together with a branch: flush wins.
        drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h380);
        tick(); // E13
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        check("fl_pc", bus.pc, 32'h380);
        check("fl_id_valid", {31'd0, bus.id_valid}, 32'd0);
        check("fl_id_inst", bus.id_inst, 32'h0);
        check("fl_count", bus.fetch_count, 32'd8);
        tick(); // E14
        check("fl2_id_pc", bus.id_pc, 32'h380);
        check("fl2_id_valid", {31'd0, bus.id_valid}, 32'd1);
        check("fl2_pc", bus.pc, 32'h384);

        // Misaligned branch target.
        drive(1'b0, 1'b1, 32'h102, 1'b0, '0);
        tick(); // E15
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        check("mis_pc", bus.pc, 32'h100);
        check("mis_pulse", {31'd0, bus.misalign}, 32'd1);
        tick(); // E16
        check("mis_clear", {31'd0, bus.misalign}, 32'd0);
        check("mis_next_pc", bus.pc, 32'h104);

        // Reset while a branch is pending discards it.
        drive(1'b1, 1'b1, 32'h300, 1'b0, '0);
        tick(); // E17
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        rst = 1'b0;
        tick(); // E18
        check("mrst_pc", bus.pc, 32'h0);
        check("mrst_ce", {31'd0, bus.ce}, 32'd0);
        check("mrst_count", bus.fetch_count, 32'd0);
        check("mrst_id_valid", {31'd0, bus.id_valid}, 32'd0);
        rst = 1'b1;
        tick(); // E19
        check("mrst_ce_on", {31'd0, bus.ce}, 32'd1);
        tick(); // E20
        check("mrst_no_pend", bus.pc, 32'h4);
        check("mrst_id_pc", bus.id_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
